// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned MUL/DIV sequencer with Hi/Lo registers.
// MUL is an iterative shift-add multiplier and DIV is a restoring divider.
// Each op takes n cycles, except that divide by zero finishes after one cycle.
// Optional build macro MULDIV_EARLY_EXIT_EN makes MUL finish early once the
// remaining multiplier bits are all zero. DIV timing does not change.
module muldiv_sequencer #(
   parameter int n = 32,
   parameter int m = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [m-1:0] alu_decode,
   input  logic [n-1:0] rda,
   input  logic [n-1:0] rdx,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] hi,
   output logic [n-1:0] lo,
   output logic         div_by_zero
);

   localparam int CW = $clog2(n) + 1;
   localparam logic [m-1:0] DEC_MUL = m'(5);
   localparam logic [m-1:0] DEC_DIV = m'(6);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q;
   logic            is_div_q;
   logic            dz_pend_q;
   logic [n-1:0]    opnd_q;     // multiplicand (MUL) or divisor (DIV)
   logic [2*n-1:0]  acc_q;      // MUL: {partial hi, multiplier/low}; DIV: {remainder, quotient}
   logic [CW-1:0]   cnt_q;
   logic            busy_q, done_q, dz_q;
   logic [n-1:0]    hi_q, lo_q;

   logic [n:0]      mul_sum;
   logic [2*n-1:0]  mul_step;
   logic [2*n-1:0]  mul_res;
   logic            mul_fin;
   logic [n:0]      div_shift;
   logic [n:0]      div_trial;
   logic [2*n-1:0]  div_step;
   logic            last;
   logic            accept;

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dz_q;

   assign accept = start && (alu_decode == DEC_MUL || alu_decode == DEC_DIV);

   // One iteration of each datapath, computed from the current accumulator.
   // The remainder never exceeds the divisor, so it is kept in n bits.
   // The (n+1)-bit working value exists only for the trial subtract.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_step  = {mul_sum, acc_q[n-1:1]};
      div_shift = {acc_q[2*n-1:n], acc_q[n-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      div_step  = div_trial[n] ? {div_shift[n-1:0], acc_q[n-2:0], 1'b0}
                               : {div_trial[n-1:0], acc_q[n-2:0], 1'b1};
      last      = (cnt_q == CW'(n - 1));
   end

`ifdef MULDIV_EARLY_EXIT_EN
   logic [n-1:0] rem_mask;
   // After this step, n-cnt-1 multiplier bits remain unshifted in the low bits.
   // If they are all zero, shift by the remaining count and stop.
   always_comb begin
      rem_mask = {n{1'b1}} >> (cnt_q + CW'(1));
      mul_fin  = ((mul_step[n-1:0] & rem_mask) == '0);
      mul_res  = mul_step >> (CW'(n - 1) - cnt_q);
   end
`else
   // Without early exit, MUL always runs the full n iterations.
   always_comb begin
      mul_fin = last;
      mul_res = mul_step;
   end
`endif

   // Sequencer FSM with registered outputs. Hi/Lo load only when entering DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         is_div_q  <= 1'b0;
         dz_pend_q <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  is_div_q  <= (alu_decode == DEC_DIV);
                  dz_pend_q <= (alu_decode == DEC_DIV) && (rdx == '0);
                  opnd_q    <= (alu_decode == DEC_DIV) ? rdx : rda;
                  acc_q     <= {{n{1'b0}}, (alu_decode == DEC_DIV) ? rda : rdx};
                  cnt_q     <= '0;
                  dz_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               cnt_q <= cnt_q + CW'(1);
               if (is_div_q && dz_pend_q) begin
                  hi_q    <= acc_q[n-1:0];
                  lo_q    <= '1;
                  dz_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (is_div_q) begin
                  acc_q <= div_step;
                  if (last) begin
                     hi_q    <= div_step[2*n-1:n];
                     lo_q    <= div_step[n-1:0];
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end else begin
                  acc_q <= mul_step;
                  if (mul_fin) begin
                     hi_q    <= mul_res[2*n-1:n];
                     lo_q    <= mul_res[n-1:0];
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench with a cycle-level reference model.
// The bench also has hand-computed expectations for results and latency.
module tb_muldiv_sequencer;

   localparam int N = 32;
`ifdef MULDIV_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    alu_decode = 4'd0;
   logic [N-1:0]  rda = '0, rdx = '0;
   logic          busy, done, div_by_zero;
   logic [N-1:0]  hi, lo;

   int n_chk = 0, n_pass = 0;
   bit chk_on = 1'b0;

   muldiv_sequencer #(.n(N), .m(4)) dut (
      .clk(clk), .reset(reset), .start(start), .alu_decode(alu_decode),
      .rda(rda), .rdx(rdx), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Reference results from plain arithmetic.
   function automatic logic [31:0] f_hi(input logic [3:0] d, input logic [31:0] a, input logic [31:0] x);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, x};
      if (d == 4'd5) return p[63:32];
      if (x == 0)    return a;
      return a % x;
   endfunction

   function automatic logic [31:0] f_lo(input logic [3:0] d, input logic [31:0] a, input logic [31:0] x);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, x};
      if (d == 4'd5) return p[31:0];
      if (x == 0)    return 32'hFFFF_FFFF;
      return a / x;
   endfunction

   function automatic int f_lat(input logic [3:0] d, input logic [31:0] x);
      int msb;
      if (d == 4'd6) return (x == 0) ? 1 : N;
      if (!EE) return N;
      msb = 0;
      for (int i = 0; i < N; i++) if (x[i]) msb = i + 1;
      return (msb < 1) ? 1 : msb;
   endfunction

   // Cycle-level model of the expected outputs.
   logic          m_busy = 0, m_done = 0, m_dz = 0;
   logic [N-1:0]  m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   logic          p_dz = 0;
   int            m_left = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 0; m_done <= 0; m_dz <= 0; m_hi <= 0; m_lo <= 0; m_left <= 0;
      end else if (m_done) begin
         m_done <= 0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 0; m_done <= 1; m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz;
         end
      end else if (start && (alu_decode == 4'd5 || alu_decode == 4'd6)) begin
         p_hi   <= f_hi(alu_decode, rda, rdx);
         p_lo   <= f_lo(alu_decode, rda, rdx);
         p_dz   <= (alu_decode == 4'd6) && (rdx == 0);
         m_left <= f_lat(alu_decode, rdx);
         m_busy <= 1; m_dz <= 0;
      end
   end

   // Compare the DUT against the model on every cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         chk("dz", div_by_zero, m_dz);
      end
   end

   // Run one op and check literal results and latency.
   // A nonzero poke pulses start with a MUL at that cycle of the run.
   task automatic run_op(input string nm, input logic [3:0] d, input logic [31:0] a, x,
                         input logic [31:0] ehi, elo, input logic edz,
                         input int ln, le, input int poke);
      int cyc;
      @(negedge clk);
      start = 1; alu_decode = d; rda = a; rdx = x;
      @(negedge clk);
      start = 0; rda = $urandom; rdx = $urandom;
      chk({nm, "_busy_on"}, busy, 1'b1);
      chk({nm, "_dz_clr"}, div_by_zero, 1'b0);
      cyc = 1;
      while (!done && cyc < 100) begin
         if (cyc == poke) begin start = 1; alu_decode = 4'd5; rda = 9; rdx = 9; end
         else start = 0;
         @(negedge clk);
         cyc++;
      end
      start = 0;
      chk({nm, "_lat"}, cyc - 1, EE ? le : ln);
      chk({nm, "_hi"}, hi, ehi);
      chk({nm, "_lo"}, lo, elo);
      chk({nm, "_dz"}, div_by_zero, edz);
      chk({nm, "_busy_off"}, busy, 1'b0);
   endtask

   initial begin
      #1 reset = 1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_dz", div_by_zero, 0);
      reset = 0;
      chk_on = 1;

      run_op("mul7x6",  4'd5, 7, 6, 0, 42, 0, 32, 3, 0);
      run_op("mulmax",  4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0, 32, 32, 0);
      run_op("mul5x0",  4'd5, 5, 0, 0, 0, 0, 32, 1, 0);
      run_op("div100",  4'd6, 100, 7, 2, 14, 0, 32, 32, 0);
      run_op("div5_9",  4'd6, 5, 9, 5, 0, 0, 32, 32, 0);
      run_op("divmax",  4'd6, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 32, 32, 0);
      run_op("divz",    4'd6, 123, 0, 123, 32'hFFFF_FFFF, 1, 1, 1, 0);
      run_op("mul3x5",  4'd5, 3, 5, 0, 15, 0, 32, 3, 0);
      run_op("divpoke", 4'd6, 100, 7, 2, 14, 0, 32, 32, 5);

      // A start with an invalid decode is ignored.
      @(negedge clk);
      start = 1; alu_decode = 4'b0001; rda = 55; rdx = 66;
      @(negedge clk);
      start = 0;
      chk("baddec_busy", busy, 0);
      repeat (2) @(negedge clk);
      chk("baddec_hi", hi, 2);
      chk("baddec_lo", lo, 14);

      // Asynchronous reset in the middle of a MUL.
      @(negedge clk);
      start = 1; alu_decode = 4'd5; rda = 32'hABCD; rdx = 32'h1234;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      #2 reset = 1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      @(negedge clk);
      reset = 0;
      run_op("mul3x4", 4'd5, 3, 4, 0, 12, 0, 32, 3, 0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
